// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Forwarding selects and watchdog FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_fwd_unit.sv
// EX-stage operand forwarding select for one source operand.
// The MEM result is younger than the WB result, so it wins.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs_e_i,
  input  logic [REG_W-1:0] rd_m_i,
  input  logic             reg_write_m_i,
  input  logic [REG_W-1:0] rd_w_i,
  input  logic             reg_write_w_i,
  output fwd_sel_e         fwd_sel_o
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m_i
               && (rd_m_i != '0)
               && (rd_m_i == rs_e_i);
  assign hit_w = reg_write_w_i
               && (rd_w_i != '0)
               && (rd_w_i == rs_e_i);

  always_comb begin
    fwd_sel_o = FWD_RF;
    if (hit_m) begin
      fwd_sel_o = FWD_MEM;
    end else if (hit_w) begin
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forwarding,
// memory-wait watchdog and saturating performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [REG_W-1:0] rs1_d_i,
  input  logic [REG_W-1:0] rs2_d_i,
  input  logic [REG_W-1:0] rs1_e_i,
  input  logic [REG_W-1:0] rs2_e_i,
  input  logic [REG_W-1:0] rd_e_i,
  input  logic             load_e_i,
  input  logic             pc_src_e_i,
  input  logic [REG_W-1:0] rd_m_i,
  input  logic             reg_write_m_i,
  input  logic [REG_W-1:0] rd_w_i,
  input  logic             reg_write_w_i,
  input  logic             mem_req_m_i,
  input  logic             mem_ack_i,
  output logic [1:0]       forward_a_e_o,
  output logic [1:0]       forward_b_e_o,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             stall_m_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             flush_w_o,
  output logic             err_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] WAIT_MAX =
    WC_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fwd_sel_e  fwd_a;
  fwd_sel_e  fwd_b;
  logic      lw_stall;
  logic      mem_stall;
  hz_state_e state_q;
  hz_state_e state_d;
  logic [WC_W-1:0]  wait_q;
  logic [WC_W-1:0]  wait_d;
  logic             err_q;
  logic             err_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  hazard_fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .rs_e_i        (rs1_e_i),
    .rd_m_i        (rd_m_i),
    .reg_write_m_i (reg_write_m_i),
    .rd_w_i        (rd_w_i),
    .reg_write_w_i (reg_write_w_i),
    .fwd_sel_o     (fwd_a)
  );

  hazard_fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .rs_e_i        (rs2_e_i),
    .rd_m_i        (rd_m_i),
    .reg_write_m_i (reg_write_m_i),
    .rd_w_i        (rd_w_i),
    .reg_write_w_i (reg_write_w_i),
    .fwd_sel_o     (fwd_b)
  );

  assign lw_stall = load_e_i
                  && (rd_e_i != '0)
                  && ((rd_e_i == rs1_d_i)
                   || (rd_e_i == rs2_d_i));
  assign mem_stall = mem_req_m_i && !mem_ack_i;

  // A taken branch waits in the frozen EX stage
  // and flushes once memory releases the pipe.
  always_comb begin
    forward_a_e_o = FWD_RF;
    forward_b_e_o = FWD_RF;
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    flush_w_o = 1'b0;
    if (rst_ni) begin
      forward_a_e_o = fwd_a;
      forward_b_e_o = fwd_b;
      if (mem_stall) begin
        stall_f_o = 1'b1;
        stall_d_o = 1'b1;
        stall_e_o = 1'b1;
        stall_m_o = 1'b1;
        flush_w_o = 1'b1;
      end else begin
        stall_f_o = lw_stall;
        stall_d_o = lw_stall;
        flush_d_o = pc_src_e_i;
        flush_e_o = lw_stall | pc_src_e_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_ack_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    wait_d = '0;
    if (mem_stall) begin
      if (wait_q == WAIT_MAX) begin
        wait_d = wait_q;
      end else begin
        wait_d = wait_q + WC_W'(1);
      end
    end
    err_d = err_q
          | (mem_stall && (wait_d == WAIT_MAX));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f_o && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_d_o && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign err_timeout_o = err_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Watchdog limit is shortened to 4 wait cycles.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  rs1_d_i, rs2_d_i;
  logic [4:0]  rs1_e_i, rs2_e_i, rd_e_i;
  logic        load_e_i, pc_src_e_i;
  logic [4:0]  rd_m_i, rd_w_i;
  logic        reg_write_m_i, reg_write_w_i;
  logic        mem_req_m_i, mem_ack_i;
  logic [1:0]  forward_a_e_o, forward_b_e_o;
  logic        stall_f_o, stall_d_o;
  logic        stall_e_o, stall_m_o;
  logic        flush_d_o, flush_e_o, flush_w_o;
  logic        err_timeout_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(
    .REG_W(5), .MAX_WAIT(4), .CNT_W(32)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rs1_d_i       (rs1_d_i),
    .rs2_d_i       (rs2_d_i),
    .rs1_e_i       (rs1_e_i),
    .rs2_e_i       (rs2_e_i),
    .rd_e_i        (rd_e_i),
    .load_e_i      (load_e_i),
    .pc_src_e_i    (pc_src_e_i),
    .rd_m_i        (rd_m_i),
    .reg_write_m_i (reg_write_m_i),
    .rd_w_i        (rd_w_i),
    .reg_write_w_i (reg_write_w_i),
    .mem_req_m_i   (mem_req_m_i),
    .mem_ack_i     (mem_ack_i),
    .forward_a_e_o (forward_a_e_o),
    .forward_b_e_o (forward_b_e_o),
    .stall_f_o     (stall_f_o),
    .stall_d_o     (stall_d_o),
    .stall_e_o     (stall_e_o),
    .stall_m_o     (stall_m_o),
    .flush_d_o     (flush_d_o),
    .flush_e_o     (flush_e_o),
    .flush_w_o     (flush_w_o),
    .err_timeout_o (err_timeout_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  task automatic idle();
    rs1_d_i = 0; rs2_d_i = 0;
    rs1_e_i = 0; rs2_e_i = 0; rd_e_i = 0;
    load_e_i = 0; pc_src_e_i = 0;
    rd_m_i = 0; rd_w_i = 0;
    reg_write_m_i = 0; reg_write_w_i = 0;
    mem_req_m_i = 0; mem_ack_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle();
    load_e_i = 1; rd_e_i = 3; rs1_d_i = 3;
    pc_src_e_i = 1;
    rs1_e_i = 2; rd_m_i = 2; reg_write_m_i = 1;
    #2;
    checks++;
    if ({stall_f_o, stall_d_o, flush_d_o,
         flush_e_o, forward_a_e_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b%b%b want=0",
        stall_f_o, stall_d_o, flush_d_o,
        flush_e_o, forward_a_e_o);
    end
    checks++;
    if ({stall_cnt_o, flush_cnt_o, err_timeout_o}
        !== 65'd0) begin
      failures++;
      $display("FAIL reset_regs scnt=%0d fcnt=%0d err=%b want 0",
        stall_cnt_o, flush_cnt_o, err_timeout_o);
    end
    @(negedge clk_i);
    idle();
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (dut.state_q !== RUN) begin
      failures++;
      $display("FAIL reset_state got=%0d want=RUN",
        dut.state_q);
    end
  endtask

  task automatic test_forward();
    @(negedge clk_i);
    rs1_e_i = 5; rd_m_i = 5; reg_write_m_i = 1;
    rd_w_i = 5; reg_write_w_i = 1;
    rs2_e_i = 9;
    #1;
    checks++;
    if (forward_a_e_o !== 2'b10) begin
      failures++;
      $display("FAIL fwd_mem got=%b want=10", forward_a_e_o);
    end
    checks++;
    if (forward_b_e_o !== 2'b00) begin
      failures++;
      $display("FAIL fwd_b_none got=%b want=00", forward_b_e_o);
    end
    rd_m_i = 0;
    #1;
    checks++;
    if (forward_a_e_o !== 2'b01) begin
      failures++;
      $display("FAIL fwd_wb got=%b want=01", forward_a_e_o);
    end
    rd_w_i = 0;
    #1;
    checks++;
    if (forward_a_e_o !== 2'b00) begin
      failures++;
      $display("FAIL fwd_rf got=%b want=00", forward_a_e_o);
    end
    rd_m_i = 9; reg_write_m_i = 0;
    rd_w_i = 9; reg_write_w_i = 1;
    #1;
    checks++;
    if (forward_b_e_o !== 2'b01) begin
      failures++;
      $display("FAIL fwd_b_wb got=%b want=01", forward_b_e_o);
    end
    idle();
  endtask

  task automatic test_load_use();
    @(negedge clk_i);
    load_e_i = 1; rd_e_i = 7; rs2_d_i = 7;
    #1;
    checks++;
    if ({stall_f_o, stall_d_o, flush_e_o, flush_d_o,
         stall_e_o} !== 5'b11100) begin
      failures++;
      $display("FAIL lw_stall got=%b%b%b%b%b want=11100",
        stall_f_o, stall_d_o, flush_e_o,
        flush_d_o, stall_e_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (stall_cnt_o !== 32'd1) begin
      failures++;
      $display("FAIL lw_cnt got=%0d want=1", stall_cnt_o);
    end
    @(negedge clk_i);
    idle();
    load_e_i = 1; rd_e_i = 0; rs1_d_i = 0;
    #1;
    checks++;
    if ({stall_f_o, stall_d_o, flush_e_o} !== 3'b000) begin
      failures++;
      $display("FAIL lw_x0 got=%b%b%b want=000",
        stall_f_o, stall_d_o, flush_e_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (stall_cnt_o !== 32'd1) begin
      failures++;
      $display("FAIL lw_x0_cnt got=%0d want=1", stall_cnt_o);
    end
    @(negedge clk_i);
    idle();
  endtask

  task automatic test_branch();
    @(negedge clk_i);
    pc_src_e_i = 1;
    #1;
    checks++;
    if ({flush_d_o, flush_e_o, stall_f_o, stall_d_o,
         flush_w_o} !== 5'b11000) begin
      failures++;
      $display("FAIL branch got=%b%b%b%b%b want=11000",
        flush_d_o, flush_e_o, stall_f_o,
        stall_d_o, flush_w_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (flush_cnt_o !== 32'd1) begin
      failures++;
      $display("FAIL branch_cnt got=%0d want=1", flush_cnt_o);
    end
    @(negedge clk_i);
    idle();
  endtask

  task automatic test_mem_wait();
    @(negedge clk_i);
    mem_req_m_i = 1; mem_ack_i = 0; pc_src_e_i = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk_i);
      #1;
      checks++;
      if ({stall_f_o, stall_d_o, stall_e_o, stall_m_o,
           flush_w_o, flush_d_o, flush_e_o}
          !== 7'b1111100) begin
        failures++;
        $display("FAIL wait_out[%0d] got=%b%b%b%b%b%b%b want=1111100",
          i, stall_f_o, stall_d_o, stall_e_o,
          stall_m_o, flush_w_o, flush_d_o, flush_e_o);
      end
      @(posedge clk_i); #1;
      checks++;
      if (dut.state_q !== MEM_WAIT) begin
        failures++;
        $display("FAIL wait_state[%0d] got=%0d want=MEM_WAIT",
          i, dut.state_q);
      end
    end
    @(negedge clk_i);
    mem_ack_i = 1;
    #1;
    checks++;
    if ({stall_f_o, stall_m_o, flush_w_o, flush_d_o,
         flush_e_o} !== 5'b00011) begin
      failures++;
      $display("FAIL ack_out got=%b%b%b%b%b want=00011",
        stall_f_o, stall_m_o, flush_w_o,
        flush_d_o, flush_e_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (dut.state_q !== RUN || stall_cnt_o !== 32'd4
        || flush_cnt_o !== 32'd2 || err_timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL ack_regs st=%0d scnt=%0d fcnt=%0d err=%b want RUN 4 2 0",
        dut.state_q, stall_cnt_o, flush_cnt_o, err_timeout_o);
    end
    @(negedge clk_i);
    idle();
    mem_req_m_i = 1; mem_ack_i = 1;
    #1;
    checks++;
    if (stall_f_o !== 1'b0 || flush_w_o !== 1'b0) begin
      failures++;
      $display("FAIL zero_wait got=%b%b want=00",
        stall_f_o, flush_w_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (dut.state_q !== RUN || stall_cnt_o !== 32'd4) begin
      failures++;
      $display("FAIL zero_wait_regs st=%0d scnt=%0d want RUN 4",
        dut.state_q, stall_cnt_o);
    end
    @(negedge clk_i);
    idle();
  endtask

  task automatic test_watchdog();
    @(negedge clk_i);
    mem_req_m_i = 1; mem_ack_i = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (err_timeout_o !== (i >= 4) || stall_m_o !== 1'b1) begin
        failures++;
        $display("FAIL wdog[%0d] err=%b stall_m=%b want err=%b stall_m=1",
          i, err_timeout_o, stall_m_o, (i >= 4));
      end
    end
    @(negedge clk_i);
    mem_ack_i = 1;
    @(posedge clk_i); #1;
    checks++;
    if (err_timeout_o !== 1'b1 || stall_cnt_o !== 32'd10) begin
      failures++;
      $display("FAIL wdog_sticky err=%b scnt=%0d want 1 10",
        err_timeout_o, stall_cnt_o);
    end
    @(negedge clk_i);
    idle();
    rst_ni = 1'b0;
    #1;
    checks++;
    if (err_timeout_o !== 1'b0 || stall_cnt_o !== 32'd0) begin
      failures++;
      $display("FAIL wdog_clear err=%b scnt=%0d want 0 0",
        err_timeout_o, stall_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk_i);
    mem_req_m_i = 1; mem_ack_i = 0; pc_src_e_i = 1;
    rs1_e_i = 5; rd_m_i = 5; reg_write_m_i = 1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    checks++;
    if (dut.state_q !== MEM_WAIT || stall_cnt_o !== 32'd2) begin
      failures++;
      $display("FAIL midwait_pre st=%0d scnt=%0d want MEM_WAIT 2",
        dut.state_q, stall_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({stall_f_o, stall_e_o, stall_m_o, flush_w_o,
         flush_d_o, forward_a_e_o} !== 7'b0) begin
      failures++;
      $display("FAIL midwait_out got=%b%b%b%b%b%b want=0",
        stall_f_o, stall_e_o, stall_m_o, flush_w_o,
        flush_d_o, forward_a_e_o);
    end
    checks++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0
        || dut.state_q !== RUN) begin
      failures++;
      $display("FAIL midwait_regs scnt=%0d fcnt=%0d st=%0d want 0 0 RUN",
        stall_cnt_o, flush_cnt_o, dut.state_q);
    end
    @(negedge clk_i);
    idle();
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (dut.state_q !== RUN || stall_cnt_o !== 32'd0) begin
      failures++;
      $display("FAIL midwait_post st=%0d scnt=%0d want RUN 0",
        dut.state_q, stall_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_watchdog();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. Produces the per-stage stall (enable) and flush (clear) controls consumed by the pipeline registers, and the EX-stage forwarding selects. Handles data-memory wait states through a small FSM with a wait-cycle watchdog. Keeps saturating stall and flush performance counters. Sits beside the datapath and drives every clearable pipeline register between IF/ID/EX/MEM/WB.

## Interface
- `REG_W`, 5: register-address width.
- `MAX_WAIT`, 15: memory wait cycles before `err_timeout_o` sets (≥1).
- `CNT_W`, 32: performance-counter width.
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `rs1_d_i`, `rs2_d_i`  in  REG_W  source registers in ID.
- `rs1_e_i`, `rs2_e_i`, `rd_e_i`  in  REG_W  source and destination registers in EX.
- `load_e_i`  in  1  EX instruction is a load.
- `pc_src_e_i`  in  1  branch/jump taken in EX.
- `rd_m_i`  in  REG_W  destination register in MEM.
- `reg_write_m_i`  in  1  register write enable in MEM.
- `rd_w_i`  in  REG_W  destination register in WB.
- `reg_write_w_i`  in  1  register write enable in WB.
- `mem_req_m_i`  in  1  MEM instruction accesses data memory.
- `mem_ack_i`  in  1  data memory completes the access this cycle.
- `forward_a_e_o`, `forward_b_e_o`  out  2  operand selects: 00 register file, 01 WB result, 10 MEM ALU result.
- `stall_f_o`, `stall_d_o`, `stall_e_o`, `stall_m_o`  out  1  hold the stage register.
- `flush_d_o`, `flush_e_o`, `flush_w_o`  out  1  clear the stage register (bubble).
- `err_timeout_o`  out  1  sticky watchdog flag.
- `stall_cnt_o`  out  CNT_W  cycles with `stall_f_o`=1.
- `flush_cnt_o`  out  CNT_W  cycles with `flush_d_o`=1.

## Operation
- **Forwarding, per operand:**
  - MEM match (`reg_write_m_i`, `rd_m_i`≠0, `rd_m_i`==rs_e) → 10.
  - Else WB match (same conditions on the WB inputs) → 01.
  - Else 00.
  - MEM has priority over WB.
- **Load-use:** `lw_stall` = `load_e_i` & `rd_e_i`≠0 & (`rd_e_i`==`rs1_d_i` | `rd_e_i`==`rs2_d_i`).
- **Memory stall:** `mem_stall` = `mem_req_m_i` & ~`mem_ack_i`.
- **Output priority:**
  - If `mem_stall`:
    - Assert all four stalls and `flush_w_o`.
    - Force `flush_d_o` and `flush_e_o` to 0. A taken branch is held in the stalled EX stage and flushes after release.
  - Else:
    - `stall_f_o` = `stall_d_o` = `lw_stall`.
    - `stall_e_o` = `stall_m_o` = `flush_w_o` = 0.
    - `flush_d_o` = `pc_src_e_i`.
    - `flush_e_o` = `lw_stall` | `pc_src_e_i`.
- **FSM states:** RUN, MEM_WAIT.
  - RUN → MEM_WAIT when `mem_stall`=1.
  - MEM_WAIT → RUN when `mem_ack_i`=1.
  - Outputs follow the equations above in both states; the state drives only the watchdog.
- **Watchdog:**
  - `wait_cnt` increments on every posedge with `mem_stall`=1, saturating at MAX_WAIT.
  - `wait_cnt` clears on any posedge with `mem_stall`=0.
  - `err_timeout_o` sets at the posedge where `wait_cnt` reaches MAX_WAIT and holds until reset. The stall continues.
- **Performance counters:** increment on qualifying posedges and saturate at all-ones; they never wrap.
- **Reset:**
  - While `rst_ni`=0, all stall/flush outputs are 0 and forwards are 00 (combinationally gated).
  - State resets to RUN; `wait_cnt`, both counters and `err_timeout_o` reset to 0.
  - Reset during MEM_WAIT abandons the wait.

## Timing
- Stall, flush and forward outputs are combinational, same cycle as their inputs. Pipeline registers act on them at the next posedge.
- Load-use costs exactly 1 bubble: the cycle after, `load_e_i` is gone from EX.
- A branch flush costs 2 bubbles (D and E).
- `mem_ack_i` in the same cycle as `mem_req_m_i` causes zero stall cycles and no FSM transition.
- An N-cycle memory wait holds F–M for N cycles and injects N WB bubbles.
- Reset deassertion takes effect on the first posedge after `rst_ni` rises. No output glitch requirement beyond combinational settling.

## Structure
- The shared package `hazard_pkg` holds:
  - `fwd_sel_e`: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - `hz_state_e`: RUN, MEM_WAIT.
- Sub-module `hazard_fwd_unit` is combinational, one operand each, instantiated twice. It takes rs_e, rd_m, reg_write_m, rd_w and reg_write_w, and outputs `fwd_sel_e`.
- FSM, watchdog and counters stay in `hazard_ctrl`.

## Test plan
- **Forwarding:**
  - Stimulus: `rs1_e_i`=5, `rd_m_i`=5, `reg_write_m_i`=1, `rd_w_i`=5, `reg_write_w_i`=1. Response: `forward_a_e_o`=10.
  - Stimulus: same with `rd_m_i`=0. Response: `forward_a_e_o`=01.
  - Stimulus: `rd_w_i`=0 as well. Response: `forward_a_e_o`=00.
- **Load-use:**
  - Stimulus: `load_e_i`=1, `rd_e_i`=7, `rs2_d_i`=7. Response: `stall_f_o`=`stall_d_o`=`flush_e_o`=1 for one cycle, `stall_cnt_o`=1.
  - Stimulus: `rd_e_i`=0. Response: no stall.
- **Branch:**
  - Stimulus: `pc_src_e_i`=1 for one cycle. Response: `flush_d_o`=`flush_e_o`=1, stalls 0, `flush_cnt_o` increments by 1.
- **Memory wait:**
  - Stimulus: `mem_req_m_i`=1, `mem_ack_i` low for 3 cycles then high. Response: all stalls and `flush_w_o`=1 for exactly 3 cycles, FSM RUN→MEM_WAIT→RUN.
  - Stimulus: concurrent `pc_src_e_i`=1 during the wait. Response: the flush appears only in the ack cycle.
- **Watchdog:**
  - Stimulus: MAX_WAIT=4, ack never arrives. Response: `err_timeout_o` rises after the 4th stalled posedge and stays high after a later ack.
  - Stimulus: `rst_ni` pulse. Response: `err_timeout_o` clears.
- **Reset mid-wait:**
  - Stimulus: assert `rst_ni`=0 in MEM_WAIT with counters nonzero. Response: outputs 0/00 immediately, counters 0, state RUN after release.
